// File: rtl/mem_bus_arbiter_if.sv
// Interface bundling the IF/MEM requester ports and the shared Wishbone-style bus
// of mem_bus_arbiter. The master modport is the arbiter's view; slave is the environment's.
//
// Handshake: a requester raises *_req_i and holds it, together with its address and
// write data, until it sees a one-cycle *_ack_o. The cycle in which *_ack_o is high is
// the consume cycle: the request may still be high but it does not start a new transfer.
// On the bus, cyc/stb are held from the grant edge until bus_ack_i is sampled high.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;
    logic              flush_i;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ack_o;

    logic              bus_cyc_o;
    logic              bus_stb_o;
    logic              bus_we_o;
    logic [3:0]        bus_sel_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i;
    logic              bus_ack_i;

    logic              stall_req_if_o;
    logic              stall_req_mem_o;
    logic              err_o;
    logic [1:0]        dbg_state;

    modport master (
        input  if_req_i, if_addr_i, flush_i,
        input  mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  bus_rdata_i, bus_ack_i,
        output if_data_o, if_ack_o, mem_rdata_o, mem_ack_o,
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        output stall_req_if_o, stall_req_mem_o, err_o, dbg_state
    );

    modport slave (
        output if_req_i, if_addr_i, flush_i,
        output mem_req_i, mem_we_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output bus_rdata_i, bus_ack_i,
        input  if_data_o, if_ack_o, mem_rdata_o, mem_ack_o,
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o,
        input  stall_req_if_o, stall_req_mem_o, err_o, dbg_state
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one Wishbone-style memory port between openmips instruction fetch and MEM stage.
// Optional bus-timeout abort is enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        IF_DROP  = 2'd3
    } state_t;

    state_t            state;
    logic              last_was_mem;
    logic              cyc_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic              if_ack_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic              mem_ack_q;

    logic arb_open;
    logic mem_wins;
    logic timed_out;

    // The ack cycle is the requester's consume cycle, so no new grant is made in it.
    assign arb_open = ~if_ack_q & ~mem_ack_q;
    assign mem_wins = bus.mem_req_i & (~bus.if_req_i | ~last_was_mem);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
    logic             in_wait;

    assign in_wait   = (state != IDLE) & ~bus.bus_ack_i;
    assign timed_out = in_wait & ((int'(wait_cnt) + 1) >= TIMEOUT);

    // Counter is held at zero in IDLE, so it starts from zero after every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timed_out;
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (in_wait) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign bus.err_o = err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign timed_out = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_was_mem <= 1'b0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_data_q    <= '0;
            if_ack_q     <= 1'b0;
            mem_rdata_q  <= '0;
            mem_ack_q    <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_open) begin
                        if (mem_wins) begin
                            state        <= MEM_BUSY;
                            last_was_mem <= 1'b1;
                            cyc_q        <= 1'b1;
                            we_q         <= bus.mem_we_i;
                            sel_q        <= bus.mem_sel_i;
                            addr_q       <= bus.mem_addr_i;
                            wdata_q      <= bus.mem_wdata_i;
                        end else if (bus.if_req_i) begin
                            state        <= IF_BUSY;
                            last_was_mem <= 1'b0;
                            cyc_q        <= 1'b1;
                            we_q         <= 1'b0;
                            sel_q        <= 4'hF;
                            addr_q       <= bus.if_addr_i;
                            wdata_q      <= '0;
                        end
                    end
                end
                // A flush arriving with the completing ack still cancels the fetch.
                IF_BUSY: begin
                    if (bus.bus_ack_i) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                        if (!bus.flush_i) begin
                            if_data_q <= bus.bus_rdata_i;
                            if_ack_q  <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                        if (!bus.flush_i) begin
                            if_data_q <= '0;
                            if_ack_q  <= 1'b1;
                        end
                    end else if (bus.flush_i) begin
                        state <= IF_DROP;
                    end
                end
                MEM_BUSY: begin
                    if (bus.bus_ack_i) begin
                        state       <= IDLE;
                        cyc_q       <= 1'b0;
                        mem_rdata_q <= bus.bus_rdata_i;
                        mem_ack_q   <= 1'b1;
                    end else if (timed_out) begin
                        state       <= IDLE;
                        cyc_q       <= 1'b0;
                        mem_rdata_q <= '0;
                        mem_ack_q   <= 1'b1;
                    end
                end
                // Cancelled fetch: keep the bus cycle open until the slave finishes it.
                IF_DROP: begin
                    if (bus.bus_ack_i || timed_out) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_cyc_o       = cyc_q;
    assign bus.bus_stb_o       = cyc_q;
    assign bus.bus_we_o        = we_q;
    assign bus.bus_sel_o       = sel_q;
    assign bus.bus_addr_o      = addr_q;
    assign bus.bus_wdata_o     = wdata_q;
    assign bus.if_data_o       = if_data_q;
    assign bus.if_ack_o        = if_ack_q;
    assign bus.mem_rdata_o     = mem_rdata_q;
    assign bus.mem_ack_o       = mem_ack_q;
    assign bus.stall_req_if_o  = bus.if_req_i & ~if_ack_q;
    assign bus.stall_req_mem_o = bus.mem_req_i & ~mem_ack_q;
    assign bus.dbg_state       = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: each cycle drives inputs just after the rising
// edge and checks outputs on the falling edge against hand-computed values.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DATA_W-1:0] exp_if_data;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus_if.if_req_i    = 1'b0;
        bus_if.if_addr_i   = '0;
        bus_if.flush_i     = 1'b0;
        bus_if.mem_req_i   = 1'b0;
        bus_if.mem_we_i    = 1'b0;
        bus_if.mem_sel_i   = 4'h0;
        bus_if.mem_addr_i  = '0;
        bus_if.mem_wdata_i = '0;
        bus_if.bus_rdata_i = '0;
        bus_if.bus_ack_i   = 1'b0;
    endtask

    task automatic drive_mem(input logic we, input logic [3:0] sel,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        bus_if.mem_req_i   = 1'b1;
        bus_if.mem_we_i    = we;
        bus_if.mem_sel_i   = sel;
        bus_if.mem_addr_i  = addr;
        bus_if.mem_wdata_i = wdata;
    endtask

    task automatic slave_ack(input logic ack, input logic [DATA_W-1:0] rdata);
        bus_if.bus_ack_i   = ack;
        bus_if.bus_rdata_i = rdata;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_if_data = '0;
        rst         = 1'b1;
        drive_idle();

        // Reset state
        settle();
        check("rst_cyc", bus_if.bus_cyc_o, 0);
        check("rst_stb", bus_if.bus_stb_o, 0);
        check("rst_if_ack", bus_if.if_ack_o, 0);
        check("rst_mem_ack", bus_if.mem_ack_o, 0);
        check("rst_addr", bus_if.bus_addr_o, 0);
        check("rst_err", bus_if.err_o, 0);
        check("rst_state", bus_if.dbg_state, 0);

        // Zero-wait IF read
        next_cycle(); rst = 1'b0;
        bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h100;
        settle();
        check("zw_c0_stall_if", bus_if.stall_req_if_o, 1);
        check("zw_c0_cyc", bus_if.bus_cyc_o, 0);
        next_cycle(); slave_ack(1'b1, 32'h3C01_1234);
        settle();
        check("zw_c1_cyc", bus_if.bus_cyc_o, 1);
        check("zw_c1_stb", bus_if.bus_stb_o, 1);
        check("zw_c1_addr", bus_if.bus_addr_o, 32'h100);
        check("zw_c1_sel", bus_if.bus_sel_o, 4'hF);
        check("zw_c1_we", bus_if.bus_we_o, 0);
        check("zw_c1_stall_if", bus_if.stall_req_if_o, 1);
        check("zw_c1_state", bus_if.dbg_state, 1);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        exp_if_data = 32'h3C01_1234;
        check("zw_c2_if_ack", bus_if.if_ack_o, 1);
        check("zw_c2_if_data", bus_if.if_data_o, exp_if_data);
        check("zw_c2_stall_if", bus_if.stall_req_if_o, 0);
        check("zw_c2_cyc", bus_if.bus_cyc_o, 0);
        check("zw_c2_err", bus_if.err_o, 0);
        // Stray slave ack while idle must be ignored
        next_cycle(); bus_if.if_req_i = 1'b0; slave_ack(1'b1, 32'hFFFF_FFFF);
        settle();
        check("zw_c3_if_ack", bus_if.if_ack_o, 0);
        check("zw_c3_cyc", bus_if.bus_cyc_o, 0);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("stray_if_ack", bus_if.if_ack_o, 0);
        check("stray_mem_ack", bus_if.mem_ack_o, 0);
        check("stray_if_data", bus_if.if_data_o, exp_if_data);

        // Contention: MEM wins first (last_was_mem = 0)
        next_cycle();
        bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h104;
        drive_mem(1'b1, 4'b0011, 32'h200, 32'hDEAD_BEEF);
        settle();
        check("ct_c0_stall_mem", bus_if.stall_req_mem_o, 1);
        next_cycle(); slave_ack(1'b1, 32'h1111_1111);
        settle();
        check("ct_c1_addr", bus_if.bus_addr_o, 32'h200);
        check("ct_c1_we", bus_if.bus_we_o, 1);
        check("ct_c1_sel", bus_if.bus_sel_o, 4'b0011);
        check("ct_c1_wdata", bus_if.bus_wdata_o, 32'hDEAD_BEEF);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("ct_c2_mem_ack", bus_if.mem_ack_o, 1);
        check("ct_c2_stall_mem", bus_if.stall_req_mem_o, 0);
        check("ct_c2_stall_if", bus_if.stall_req_if_o, 1);
        next_cycle(); bus_if.mem_req_i = 1'b0;
        settle();
        check("ct_c3_cyc", bus_if.bus_cyc_o, 0);
        check("ct_c3_mem_ack", bus_if.mem_ack_o, 0);
        next_cycle(); slave_ack(1'b1, 32'hAAAA_0001);
        drive_mem(1'b0, 4'hF, 32'h204, 32'h0);
        settle();
        check("ct_c4_addr", bus_if.bus_addr_o, 32'h104);
        check("ct_c4_we", bus_if.bus_we_o, 0);
        check("ct_c4_sel", bus_if.bus_sel_o, 4'hF);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        exp_if_data = 32'hAAAA_0001;
        check("ct_c5_if_ack", bus_if.if_ack_o, 1);
        check("ct_c5_if_data", bus_if.if_data_o, exp_if_data);
        next_cycle(); bus_if.if_addr_i = 32'h108;
        settle();
        check("ct_c6_cyc", bus_if.bus_cyc_o, 0);
        next_cycle(); slave_ack(1'b1, 32'h55AA_55AA);
        settle();
        check("ct_c7_mem_wins", bus_if.bus_addr_o, 32'h204);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("ct_c8_mem_ack", bus_if.mem_ack_o, 1);
        check("ct_c8_mem_rdata", bus_if.mem_rdata_o, 32'h55AA_55AA);
        next_cycle(); drive_mem(1'b0, 4'hF, 32'h20C, 32'h0);
        settle();
        next_cycle(); slave_ack(1'b1, 32'h0000_0108);
        settle();
        check("ct_c10_if_wins", bus_if.bus_addr_o, 32'h108);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        exp_if_data = 32'h0000_0108;
        check("ct_c11_if_ack", bus_if.if_ack_o, 1);
        check("ct_c11_if_data", bus_if.if_data_o, exp_if_data);
        next_cycle(); bus_if.if_req_i = 1'b0;
        settle();
        next_cycle(); slave_ack(1'b1, 32'h0);
        settle();
        check("ct_c13_addr", bus_if.bus_addr_o, 32'h20C);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("ct_c14_mem_ack", bus_if.mem_ack_o, 1);
        next_cycle(); bus_if.mem_req_i = 1'b0;
        settle();

        // Wait states: ack delayed three cycles
        next_cycle(); drive_mem(1'b0, 4'hF, 32'h300, 32'h0);
        settle();
        check("ws_c0_stall_mem", bus_if.stall_req_mem_o, 1);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            settle();
            check("ws_wait_cyc", bus_if.bus_cyc_o, 1);
            check("ws_wait_stall_mem", bus_if.stall_req_mem_o, 1);
        end
        next_cycle(); slave_ack(1'b1, 32'hCAFE_F00D);
        settle();
        check("ws_c4_cyc", bus_if.bus_cyc_o, 1);
        check("ws_c4_mem_ack", bus_if.mem_ack_o, 0);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("ws_c5_mem_ack", bus_if.mem_ack_o, 1);
        check("ws_c5_mem_rdata", bus_if.mem_rdata_o, 32'hCAFE_F00D);
        check("ws_c5_cyc", bus_if.bus_cyc_o, 0);
        check("ws_c5_stall_mem", bus_if.stall_req_mem_o, 0);
        next_cycle(); bus_if.mem_req_i = 1'b0;
        settle();
        check("ws_c6_mem_ack", bus_if.mem_ack_o, 0);
        check("ws_c6_rdata_hold", bus_if.mem_rdata_o, 32'hCAFE_F00D);

        // Flush during IF_BUSY with a pending MEM request
        next_cycle(); bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h400;
        settle();
        next_cycle();
        settle();
        check("fl_c1_state", bus_if.dbg_state, 1);
        next_cycle(); bus_if.flush_i = 1'b1;
        drive_mem(1'b1, 4'hF, 32'h500, 32'h1234_5678);
        settle();
        next_cycle(); bus_if.flush_i = 1'b0; bus_if.if_req_i = 1'b0;
        settle();
        check("fl_c3_state", bus_if.dbg_state, 3);
        check("fl_c3_cyc", bus_if.bus_cyc_o, 1);
        check("fl_c3_addr", bus_if.bus_addr_o, 32'h400);
        next_cycle(); slave_ack(1'b1, 32'hBAD0_BAD0);
        settle();
        check("fl_c4_cyc", bus_if.bus_cyc_o, 1);
        check("fl_c4_if_ack", bus_if.if_ack_o, 0);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("fl_c5_cyc", bus_if.bus_cyc_o, 0);
        check("fl_c5_if_ack", bus_if.if_ack_o, 0);
        check("fl_c5_if_data", bus_if.if_data_o, exp_if_data);
        check("fl_c5_state", bus_if.dbg_state, 0);
        next_cycle(); slave_ack(1'b1, 32'h0);
        settle();
        check("fl_c6_cyc", bus_if.bus_cyc_o, 1);
        check("fl_c6_addr", bus_if.bus_addr_o, 32'h500);
        check("fl_c6_we", bus_if.bus_we_o, 1);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("fl_c7_mem_ack", bus_if.mem_ack_o, 1);
        next_cycle(); bus_if.mem_req_i = 1'b0;
        settle();

        // Flush coinciding with the completing ack
        next_cycle(); bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h800;
        settle();
        next_cycle(); bus_if.flush_i = 1'b1; slave_ack(1'b1, 32'h0BAD_F00D);
        settle();
        next_cycle(); bus_if.flush_i = 1'b0; bus_if.if_req_i = 1'b0; slave_ack(1'b0, '0);
        settle();
        check("fa_if_ack", bus_if.if_ack_o, 0);
        check("fa_cyc", bus_if.bus_cyc_o, 0);
        check("fa_if_data", bus_if.if_data_o, exp_if_data);
        check("fa_state", bus_if.dbg_state, 0);

        // Asynchronous reset in MEM_BUSY
        next_cycle(); drive_mem(1'b0, 4'hF, 32'h600, 32'h0);
        settle();
        next_cycle();
        settle();
        check("rm_c1_cyc", bus_if.bus_cyc_o, 1);
        next_cycle();
        #1 rst = 1'b1;
        #1;
        check("rm_cyc", bus_if.bus_cyc_o, 0);
        check("rm_stb", bus_if.bus_stb_o, 0);
        check("rm_addr", bus_if.bus_addr_o, 0);
        check("rm_sel", bus_if.bus_sel_o, 0);
        check("rm_mem_ack", bus_if.mem_ack_o, 0);
        check("rm_if_data", bus_if.if_data_o, 0);
        check("rm_mem_rdata", bus_if.mem_rdata_o, 0);
        check("rm_state", bus_if.dbg_state, 0);
        exp_if_data = '0;
        bus_if.mem_req_i = 1'b0;
        settle();
        next_cycle(); rst = 1'b0;
        settle();
        next_cycle(); bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h700;
        settle();
        next_cycle(); slave_ack(1'b1, 32'h2402_0007);
        settle();
        check("rr_cyc", bus_if.bus_cyc_o, 1);
        check("rr_addr", bus_if.bus_addr_o, 32'h700);
        next_cycle(); slave_ack(1'b0, '0);
        settle();
        check("rr_if_ack", bus_if.if_ack_o, 1);
        check("rr_if_data", bus_if.if_data_o, 32'h2402_0007);
        next_cycle(); bus_if.if_req_i = 1'b0;
        settle();

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Timeout with TIMEOUT = 4 and a silent slave
        next_cycle(); drive_mem(1'b0, 4'hF, 32'h900, 32'h0);
        settle();
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            settle();
            check("to_wait_cyc", bus_if.bus_cyc_o, 1);
            check("to_wait_err", bus_if.err_o, 0);
        end
        next_cycle();
        settle();
        check("to_cyc", bus_if.bus_cyc_o, 0);
        check("to_mem_ack", bus_if.mem_ack_o, 1);
        check("to_mem_rdata", bus_if.mem_rdata_o, 0);
        check("to_err", bus_if.err_o, 1);
        next_cycle(); bus_if.mem_req_i = 1'b0;
        settle();
        check("to_err_pulse", bus_if.err_o, 0);
        check("to_ack_pulse", bus_if.mem_ack_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one Wishbone-style memory port between instruction fetch (IF) and the data memory stage (MEM) of the openmips pipeline.
- Sequences each bus transfer and returns read data and a one-cycle acknowledge to the winning requester.
- Raises per-stage stall requests to ctrl while a requester waits.
- Handles branch/flush cancellation of in-flight fetches.

Parameters:
- ADDR_W, 32, address width of both requesters and the bus.
- DATA_W, 32, data width.
- TIMEOUT, 255, cycles without bus_ack_i before a transfer is aborted; used only with the optional feature.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req_i  input  1  fetch request; held until if_ack_o.
- if_addr_i  input  ADDR_W  fetch address.
- if_data_o  output  DATA_W  fetched instruction; valid with if_ack_o.
- if_ack_o  output  1  one-cycle fetch completion.
- flush_i  input  1  cancel any in-flight fetch.
- mem_req_i  input  1  data request; held until mem_ack_o.
- mem_we_i  input  1  1 = write.
- mem_sel_i  input  4  byte enables.
- mem_addr_i  input  ADDR_W  data address.
- mem_wdata_i  input  DATA_W  write data.
- mem_rdata_o  output  DATA_W  read data; valid with mem_ack_o.
- mem_ack_o  output  1  one-cycle data completion.
- bus_cyc_o, bus_stb_o  output  1  bus cycle/strobe, always equal.
- bus_we_o  output  1  write enable.
- bus_sel_o  output  4  byte enables (4'b1111 for fetch).
- bus_addr_o  output  ADDR_W  bus address.
- bus_wdata_o  output  DATA_W  bus write data.
- bus_rdata_i  input  DATA_W  bus read data.
- bus_ack_i  input  1  slave acknowledge.
- stall_req_if_o  output  1  = if_req_i & ~if_ack_o (combinational).
- stall_req_mem_o  output  1  = mem_req_i & ~mem_ack_o (combinational).
- err_o  output  1  one-cycle timeout flag; tied 0 without the feature.

Behaviour:
- States: IDLE, IF_BUSY, MEM_BUSY, IF_DROP.
- Reset: async, effective immediately, including mid-transfer.
  - State goes to IDLE; last_was_mem = 0.
  - All outputs are 0, including all bus outputs and both data outputs.
- All bus outputs are registered.
- Arbitration in IDLE:
  - No arbitration occurs while if_ack_o or mem_ack_o is high. This is the consume cycle; the requester's held request must not restart a transfer.
  - Only one requester active: it wins.
  - Both active: MEM wins unless last_was_mem = 1, in which case IF wins.
  - last_was_mem is set on a MEM grant and cleared on an IF grant.
- Grant: on the granting edge, latch address, we, sel and wdata onto the bus and assert bus_cyc_o/bus_stb_o.
  - IF grants force bus_we_o = 0 and bus_sel_o = 4'b1111.
  - The next state is X_BUSY.
- X_BUSY with bus_ack_i sampled high:
  - Drop cyc/stb.
  - Register bus_rdata_i into the winner's data output; writes return the sampled bus value, which is don't-care.
  - Pulse the winner's ack for exactly one cycle.
  - Return to IDLE.
- Latency for a zero-wait slave: request at cycle 0, strobe at cycle 1, ack_o at cycle 2, next grant at cycle 3 or later.
- Each slave wait state adds one cycle.
- flush_i in IF_BUSY:
  - Go to IF_DROP; cyc/stb stay asserted until bus_ack_i.
  - The ack is then absorbed with no if_ack_o and no if_data_o update, and the state returns to IDLE.
  - Arbitration resumes on the following cycle.
- flush_i in other states: no effect on MEM transfers or on an already-asserted if_ack_o.
- flush_i together with the completing bus_ack_i in IF_BUSY: flush wins and if_ack_o is suppressed.
- Data outputs hold their last value between acks.
- bus_ack_i outside a BUSY/DROP state is ignored.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on every grant and counts each BUSY/DROP cycle without bus_ack_i.
  - When the count reaches TIMEOUT: drop cyc/stb and return to IDLE.
  - From IF_BUSY or MEM_BUSY: pulse the owner's ack with data 0 and pulse err_o in the same cycle.
  - From IF_DROP: pulse err_o only.
- Undefined: transfers wait for bus_ack_i indefinitely; err_o is constant 0; no counter logic.

Test Plan:
- Zero-wait IF read: if_req_i=1, if_addr_i=0x100, slave acks at cycle 1 with 0x3C011234 -> bus_addr_o=0x100 and sel=4'hF at cycle 1; if_ack_o=1 with if_data_o=0x3C011234 at cycle 2; stall_req_if_o=1 at cycles 0-1 and 0 at cycle 2.
- Simultaneous requests: both held, slave zero-wait -> MEM (write 0xDEADBEEF to 0x200, sel 4'b0011) is granted first; IF is granted at cycle 3 with if_ack_o at cycle 5; then with MEM re-requesting, IF (last_was_mem cleared) loses the next contention.
- Wait states: slave delays ack 3 cycles -> cyc/stb held for 4 cycles; mem_ack_o one cycle after the ack; stall_req_mem_o high throughout.
- Flush: IF_BUSY and flush_i=1 at cycle 2, slave acks at cycle 4 -> no if_ack_o; cyc drops after cycle 4; a pending MEM request is granted at cycle 5.
- Reset mid-transfer: rst=1 while in MEM_BUSY -> bus_cyc_o, mem_ack_o and all outputs go to 0 without a clock edge; after release, a new IF request proceeds normally.
- Timeout (MEM_BUS_ARB_TIMEOUT_EN, TIMEOUT=4): no slave ack -> at the 4th wait cycle cyc drops; mem_ack_o=1, mem_rdata_o=0 and err_o=1 for one cycle.
